// File: rtl/uart_pkg.sv
// Shared UART definitions: receive FSM encoding, data-length codes, oversampling constants.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_BRK_WAIT
  } uart_rx_state_t;

  localparam logic [1:0] UART_LEN_5 = 2'b00;
  localparam logic [1:0] UART_LEN_6 = 2'b01;
  localparam logic [1:0] UART_LEN_7 = 2'b10;
  localparam logic [1:0] UART_LEN_8 = 2'b11;

  localparam int unsigned UART_OVERSAMPLE = 16;
  localparam int unsigned UART_MID        = 7;

  // Index of the last data bit for a length code (5..8 bits -> 4..7).
  function automatic logic [2:0] uart_last_bit(input logic [1:0] len);
    return {1'b1, len};
  endfunction

endpackage

// File: rtl/uart_sync_cell.sv
// N-flop synchroniser for asynchronous idle-high inputs; all stages reset to 1.
module uart_sync_cell #(
  parameter int unsigned STAGES = 2
) (
  input  logic sys_clk,
  input  logic rst_b,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] ff;

  always_ff @(posedge sys_clk or negedge rst_b) begin
    if (!rst_b) ff <= '1;
    else        ff <= {ff[STAGES-2:0], d};
  end

  assign q = ff[STAGES-1];

endmodule

// File: rtl/uart_rx_frame.sv
// UART receive engine: start validation, mid-bit sampling of 5-8 data bits,
// optional parity and first stop bit, one-cycle valid pulse with status.
module uart_rx_frame
  import uart_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       sys_clk,
  input  logic       rst_b,
  input  logic       receive_clk_en,
  input  logic       uart_rxd,
  input  logic [1:0] ctrl_rx_data_len,
  input  logic       ctrl_rx_parity_en,
  input  logic       ctrl_rx_parity_even,
  input  logic       ctrl_rx_abort,
  output logic [7:0] rx_data,
  output logic       rx_data_vld,
  output logic       rx_parity_err,
  output logic       rx_frame_err,
  output logic       rx_break,
  output logic       rx_busy
);

  localparam logic [3:0] TICK_MID  = 4'(UART_MID);
  localparam logic [3:0] TICK_LAST = 4'(UART_OVERSAMPLE - 1);

  logic           rxd_s;
  uart_rx_state_t state;
  logic [3:0]     tick_cnt;
  logic [2:0]     bit_cnt;
  logic [1:0]     len_q;
  logic           par_en_q;
  logic           par_even_q;
  logic [7:0]     data_reg;
  logic           data_xor;
  logic           all_zero;
  logic           perr_q;

  uart_sync_cell #(
    .STAGES (SYNC_STAGES)
  ) u_rxd_sync (
    .sys_clk (sys_clk),
    .rst_b   (rst_b),
    .d       (uart_rxd),
    .q       (rxd_s)
  );

  // Frame FSM with counters, accumulators and registered outputs.
  always_ff @(posedge sys_clk or negedge rst_b) begin
    if (!rst_b) begin
      state         <= ST_IDLE;
      tick_cnt      <= 4'd0;
      bit_cnt       <= 3'd0;
      len_q         <= UART_LEN_8;
      par_en_q      <= 1'b0;
      par_even_q    <= 1'b0;
      data_reg      <= 8'd0;
      data_xor      <= 1'b0;
      all_zero      <= 1'b0;
      perr_q        <= 1'b0;
      rx_data       <= 8'd0;
      rx_data_vld   <= 1'b0;
      rx_parity_err <= 1'b0;
      rx_frame_err  <= 1'b0;
      rx_break      <= 1'b0;
      rx_busy       <= 1'b0;
    end else begin
      rx_data_vld <= 1'b0;
      if (ctrl_rx_abort) begin
        state    <= ST_IDLE;
        tick_cnt <= 4'd0;
        bit_cnt  <= 3'd0;
        rx_busy  <= 1'b0;
      end else if (receive_clk_en) begin
        tick_cnt <= tick_cnt + 4'd1;
        case (state)
          ST_IDLE: begin
            if (!rxd_s) begin
              state      <= ST_START;
              tick_cnt   <= 4'd0;
              rx_busy    <= 1'b1;
              len_q      <= ctrl_rx_data_len;
              par_en_q   <= ctrl_rx_parity_en;
              par_even_q <= ctrl_rx_parity_even;
              data_reg   <= 8'd0;
              data_xor   <= 1'b0;
              all_zero   <= 1'b1;
              perr_q     <= 1'b0;
            end
          end
          ST_START: begin
            if (tick_cnt == TICK_MID) begin
              if (rxd_s) begin
                state   <= ST_IDLE;
                rx_busy <= 1'b0;
              end else begin
                state    <= ST_DATA;
                tick_cnt <= 4'd0;
                bit_cnt  <= 3'd0;
              end
            end
          end
          ST_DATA: begin
            if (tick_cnt == TICK_LAST) begin
              data_reg[bit_cnt] <= rxd_s;
              data_xor          <= data_xor ^ rxd_s;
              all_zero          <= all_zero & ~rxd_s;
              bit_cnt           <= bit_cnt + 3'd1;
              if (bit_cnt == uart_last_bit(len_q))
                state <= par_en_q ? ST_PARITY : ST_STOP;
            end
          end
          ST_PARITY: begin
            if (tick_cnt == TICK_LAST) begin
              perr_q   <= data_xor ^ rxd_s ^ ~par_even_q;
              all_zero <= all_zero & ~rxd_s;
              state    <= ST_STOP;
            end
          end
          ST_STOP: begin
            if (tick_cnt == TICK_LAST) begin
              rx_data       <= data_reg;
              rx_parity_err <= perr_q;
              rx_frame_err  <= ~rxd_s;
              rx_break      <= all_zero & ~rxd_s;
              rx_data_vld   <= 1'b1;
              // A low stop bit parks the FSM until the line returns high.
              if (rxd_s) begin
                state   <= ST_IDLE;
                rx_busy <= 1'b0;
              end else begin
                state <= ST_BRK_WAIT;
              end
            end
          end
          ST_BRK_WAIT: begin
            if (rxd_s) begin
              state   <= ST_IDLE;
              rx_busy <= 1'b0;
            end
          end
          default: begin
            state   <= ST_IDLE;
            rx_busy <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_frame.sv
// Directed bench for uart_rx_frame: clean frames, parity, 5-bit at divisor 4,
// start glitch, break, abort at the stop sample and asynchronous reset.
module tb_uart_rx_frame;

  logic       sys_clk;
  logic       rst_b;
  logic       receive_clk_en;
  logic       uart_rxd;
  logic [1:0] ctrl_rx_data_len;
  logic       ctrl_rx_parity_en;
  logic       ctrl_rx_parity_even;
  logic       ctrl_rx_abort;
  logic [7:0] rx_data;
  logic       rx_data_vld;
  logic       rx_parity_err;
  logic       rx_frame_err;
  logic       rx_break;
  logic       rx_busy;

  int n_checks  = 0;
  int n_errors  = 0;
  int tick_num  = 0;
  int vld_cnt   = 0;
  int vld_tick  = 0;
  int t_drive   = 0;
  int div       = 1;
  int div_cnt   = 0;
  int base_cnt  = 0;
  bit drive_flag = 1'b0;

  uart_rx_frame #(
    .SYNC_STAGES (2)
  ) dut (
    .sys_clk             (sys_clk),
    .rst_b               (rst_b),
    .receive_clk_en      (receive_clk_en),
    .uart_rxd            (uart_rxd),
    .ctrl_rx_data_len    (ctrl_rx_data_len),
    .ctrl_rx_parity_en   (ctrl_rx_parity_en),
    .ctrl_rx_parity_even (ctrl_rx_parity_even),
    .ctrl_rx_abort       (ctrl_rx_abort),
    .rx_data             (rx_data),
    .rx_data_vld         (rx_data_vld),
    .rx_parity_err       (rx_parity_err),
    .rx_frame_err        (rx_frame_err),
    .rx_break            (rx_break),
    .rx_busy             (rx_busy)
  );

  initial begin
    sys_clk = 1'b0;
    forever #5 sys_clk = ~sys_clk;
  end

  // Tick generator with programmable divisor, updated away from the active edge.
  initial receive_clk_en = 1'b1;
  always @(negedge sys_clk) begin
    if (div_cnt >= div - 1) div_cnt = 0;
    else                    div_cnt = div_cnt + 1;
    receive_clk_en = (div_cnt == 0);
  end

  always @(posedge sys_clk) if (receive_clk_en) tick_num <= tick_num + 1;

  always @(negedge sys_clk) begin
    if (rx_data_vld) begin
      vld_cnt  = vld_cnt + 1;
      vld_tick = tick_num;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, got timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks = n_checks + 1;
    if (got !== exp) begin
      n_errors = n_errors + 1;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Wait for n tick edges, then return at the following falling edge.
  task automatic wait_ticks(input int n);
    repeat (n) begin
      @(posedge sys_clk);
      while (!receive_clk_en) @(posedge sys_clk);
    end
    @(negedge sys_clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input int nbits, input logic par_en,
                            input logic par_bit, input logic stop_bit);
    wait_ticks(1);
    t_drive    = tick_num;
    drive_flag = 1'b1;
    uart_rxd   = 1'b0;
    wait_ticks(16);
    for (int i = 0; i < nbits; i++) begin
      uart_rxd = d[i];
      wait_ticks(16);
    end
    if (par_en) begin
      uart_rxd = par_bit;
      wait_ticks(16);
    end
    uart_rxd = stop_bit;
    wait_ticks(16);
    uart_rxd = 1'b1;
  endtask

  task automatic set_ctrl(input logic [1:0] len, input logic pen, input logic peven);
    ctrl_rx_data_len    = len;
    ctrl_rx_parity_en   = pen;
    ctrl_rx_parity_even = peven;
  endtask

  initial begin
    rst_b         = 1'b0;
    uart_rxd      = 1'b1;
    ctrl_rx_abort = 1'b0;
    set_ctrl(2'b11, 1'b0, 1'b0);
    #32;
    check("rst_data",  32'(rx_data), 32'h0);
    check("rst_vld",   32'(rx_data_vld), 32'h0);
    check("rst_perr",  32'(rx_parity_err), 32'h0);
    check("rst_ferr",  32'(rx_frame_err), 32'h0);
    check("rst_brk",   32'(rx_break), 32'h0);
    check("rst_busy",  32'(rx_busy), 32'h0);
    @(negedge sys_clk);
    rst_b = 1'b1;
    wait_ticks(20);

    // 8N1 0xA5, tick every cycle: valid 2 sync + 1 detect + 152 ticks after drive
    send_frame(8'hA5, 8, 1'b0, 1'b0, 1'b1);
    wait_ticks(4);
    check("8n1_count", 32'(vld_cnt), 32'd1);
    check("8n1_lat",   32'(vld_tick - t_drive), 32'd155);
    check("8n1_data",  32'(rx_data), 32'hA5);
    check("8n1_perr",  32'(rx_parity_err), 32'h0);
    check("8n1_ferr",  32'(rx_frame_err), 32'h0);
    check("8n1_brk",   32'(rx_break), 32'h0);
    check("8n1_busy",  32'(rx_busy), 32'h0);

    // 7E1 0x41 with wrong parity bit 1
    set_ctrl(2'b10, 1'b1, 1'b1);
    send_frame(8'h41, 7, 1'b1, 1'b1, 1'b1);
    wait_ticks(4);
    check("7e1_count", 32'(vld_cnt), 32'd2);
    check("7e1_data",  32'(rx_data), 32'h41);
    check("7e1_perr",  32'(rx_parity_err), 32'h1);
    check("7e1_ferr",  32'(rx_frame_err), 32'h0);

    // 8O1 0x41 with correct parity bit 1; control changed mid-frame is ignored
    set_ctrl(2'b11, 1'b1, 1'b0);
    fork
      send_frame(8'h41, 8, 1'b1, 1'b1, 1'b1);
      begin
        wait_ticks(40);
        set_ctrl(2'b00, 1'b0, 1'b1);
      end
    join
    wait_ticks(4);
    check("8o1_count", 32'(vld_cnt), 32'd3);
    check("8o1_data",  32'(rx_data), 32'h41);
    check("8o1_perr",  32'(rx_parity_err), 32'h0);

    // 5N1 0x1F at divisor 4: detect on first tick after drive, 104 ticks to valid
    div = 4;
    set_ctrl(2'b00, 1'b0, 1'b0);
    wait_ticks(4);
    send_frame(8'hFF, 5, 1'b0, 1'b0, 1'b1);
    wait_ticks(4);
    check("5n1_count", 32'(vld_cnt), 32'd4);
    check("5n1_lat",   32'(vld_tick - t_drive), 32'd105);
    check("5n1_data",  32'(rx_data), 32'h1F);
    div = 1;
    set_ctrl(2'b11, 1'b0, 1'b0);
    wait_ticks(8);

    // Start glitch: low for 4 ticks, rejected at the mid-start sample
    wait_ticks(1);
    uart_rxd = 1'b0;
    wait_ticks(4);
    uart_rxd = 1'b1;
    wait_ticks(6);
    check("glitch_busy_hi", 32'(rx_busy), 32'h1);
    wait_ticks(1);
    check("glitch_busy_lo", 32'(rx_busy), 32'h0);
    wait_ticks(200);
    check("glitch_novld", 32'(vld_cnt), 32'd4);

    // Break: line low for 20 bit times
    wait_ticks(1);
    t_drive  = tick_num;
    uart_rxd = 1'b0;
    wait_ticks(320);
    check("brk_count", 32'(vld_cnt), 32'd5);
    check("brk_lat",   32'(vld_tick - t_drive), 32'd155);
    check("brk_data",  32'(rx_data), 32'h0);
    check("brk_ferr",  32'(rx_frame_err), 32'h1);
    check("brk_flag",  32'(rx_break), 32'h1);
    check("brk_busy",  32'(rx_busy), 32'h1);
    uart_rxd = 1'b1;
    wait_ticks(40);
    check("brk_idle",  32'(rx_busy), 32'h0);
    check("brk_single", 32'(vld_cnt), 32'd5);
    send_frame(8'h55, 8, 1'b0, 1'b0, 1'b1);
    wait_ticks(4);
    check("post_brk_count", 32'(vld_cnt), 32'd6);
    check("post_brk_data",  32'(rx_data), 32'h55);
    check("post_brk_ferr",  32'(rx_frame_err), 32'h0);
    check("post_brk_brk",   32'(rx_break), 32'h0);

    // Abort coinciding with the stop sample tick
    drive_flag = 1'b0;
    fork
      send_frame(8'hC3, 8, 1'b0, 1'b0, 1'b1);
      begin
        wait (drive_flag);
        wait_ticks(154);
        ctrl_rx_abort = 1'b1;
        @(negedge sys_clk);
        ctrl_rx_abort = 1'b0;
        check("abort_idle", 32'(rx_busy), 32'h0);
      end
    join
    wait_ticks(20);
    check("abort_novld", 32'(vld_cnt), 32'd6);
    check("abort_hold",  32'(rx_data), 32'h55);

    // Asynchronous reset in the middle of DATA
    drive_flag = 1'b0;
    base_cnt   = vld_cnt;
    fork
      send_frame(8'h3C, 8, 1'b0, 1'b0, 1'b1);
      begin
        wait (drive_flag);
        wait_ticks(60);
        check("pre_rst_busy", 32'(rx_busy), 32'h1);
        rst_b = 1'b0;
        #1;
        check("mid_rst_data", 32'(rx_data), 32'h0);
        check("mid_rst_busy", 32'(rx_busy), 32'h0);
        check("mid_rst_vld",  32'(rx_data_vld), 32'h0);
        check("mid_rst_ferr", 32'(rx_frame_err), 32'h0);
      end
    join
    @(negedge sys_clk);
    rst_b = 1'b1;
    wait_ticks(20);
    check("post_rst_busy", 32'(rx_busy), 32'h0);
    check("post_rst_novld", 32'(vld_cnt), 32'(base_cnt));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
